// File: rtl/bpmc_step_sequencer.sv
// ---------------------------------------------------------------------------
// bpmc_step_sequencer
//
// Walks a waveform-memory read address through a programmed [start..end]
// window, one address per step strobe received from the BPMC pulse stage.
// Runs continuously or for a programmed number of passes through the window.
//
// Parameters:
//   AW          address width of the waveform memory
//   CW          width of the pass (burst) counter
//
// Ports:
//   Clock       system clock, rising edge
//   Reset       synchronous active-low reset
//   M_IN        step strobe (M_OUT of the pulse stage)
//   Start       start request, sampled in IDLE only
//   Stop        abort request, honoured in every state
//   Start_Addr  first address of the window
//   End_Addr    last address of the window (may be below Start_Addr: the
//               window then wraps through 2^AW-1 -> 0)
//   Burst_Cnt   number of passes, 0 = continuous
//   Addr        current waveform address (registered)
//   Addr_Valid  Addr is live (RUN only)
//   Busy        high in RUN and DONE
//   Wrap        one-cycle pulse when Addr reloads from End to Start
//   Done        one-cycle pulse when the burst completes
//
// Build option:
//   BPMC_STEP_EDGE_DET_EN  when defined, a step is the rising edge of M_IN
//                          rather than every high cycle of M_IN.
// ---------------------------------------------------------------------------
module bpmc_step_sequencer #(
    parameter int AW = 8,
    parameter int CW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          M_IN,
    input  logic          Start,
    input  logic          Stop,
    input  logic [AW-1:0] Start_Addr,
    input  logic [AW-1:0] End_Addr,
    input  logic [CW-1:0] Burst_Cnt,
    output logic [AW-1:0] Addr,
    output logic          Addr_Valid,
    output logic          Busy,
    output logic          Wrap,
    output logic          Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] start_l;
    logic [AW-1:0] end_l;
    logic [CW-1:0] burst_l;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] pass_next;
    logic          step;

`ifdef BPMC_STEP_EDGE_DET_EN
    logic m_in_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            m_in_d <= 1'b0;
        end else begin
            m_in_d <= M_IN;
        end
    end

    // A held-high strobe counts once; latency matches the plain strobe.
    always_comb begin
        step = M_IN & ~m_in_d;
    end
`else
    always_comb begin
        step = M_IN;
    end
`endif

    // Pass counter saturates so continuous mode never rolls over.
    always_comb begin
        pass_next = (pass_cnt == '1) ? pass_cnt : pass_cnt + CW'(1);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            start_l    <= '0;
            end_l      <= '0;
            burst_l    <= '0;
            pass_cnt   <= '0;
            Addr       <= '0;
            Addr_Valid <= 1'b0;
            Busy       <= 1'b0;
            Wrap       <= 1'b0;
            Done       <= 1'b0;
        end else if (Stop) begin
            // Abort wins over everything; Addr is left where it stopped.
            state      <= ST_IDLE;
            Addr_Valid <= 1'b0;
            Busy       <= 1'b0;
            Wrap       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Wrap <= 1'b0;
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        start_l    <= Start_Addr;
                        end_l      <= End_Addr;
                        burst_l    <= Burst_Cnt;
                        pass_cnt   <= '0;
                        Addr       <= Start_Addr;
                        Addr_Valid <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= ST_RUN;
                    end else begin
                        Addr_Valid <= 1'b0;
                        Busy       <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (step) begin
                        if (Addr != end_l) begin
                            Addr <= Addr + AW'(1);
                        end else begin
                            Addr     <= start_l;
                            Wrap     <= 1'b1;
                            pass_cnt <= pass_next;
                            if ((burst_l != '0) && (pass_next == burst_l)) begin
                                state      <= ST_DONE;
                                Addr_Valid <= 1'b0;
                                Done       <= 1'b1;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state      <= ST_IDLE;
                    Addr_Valid <= 1'b0;
                    Busy       <= 1'b0;
                end

                default: begin
                    state      <= ST_IDLE;
                    Addr_Valid <= 1'b0;
                    Busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpmc_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bpmc_step_sequencer
//
// Self-checking bench for bpmc_step_sequencer (AW=8, CW=8). A behavioural
// model tracks the sequencer as "position within a window of length L" and
// a pass count, and predicts every registered output for each clock.
// Honours BPMC_STEP_EDGE_DET_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bpmc_step_sequencer;

    logic       Clock;
    logic       Reset;
    logic       M_IN;
    logic       Start;
    logic       Stop;
    logic [7:0] Start_Addr;
    logic [7:0] End_Addr;
    logic [7:0] Burst_Cnt;
    logic [7:0] Addr;
    logic       Addr_Valid;
    logic       Busy;
    logic       Wrap;
    logic       Done;

    int vectors;
    int miscompares;

    bpmc_step_sequencer #(.AW(8), .CW(8)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .M_IN       (M_IN),
        .Start      (Start),
        .Stop       (Stop),
        .Start_Addr (Start_Addr),
        .End_Addr   (End_Addr),
        .Burst_Cnt  (Burst_Cnt),
        .Addr       (Addr),
        .Addr_Valid (Addr_Valid),
        .Busy       (Busy),
        .Wrap       (Wrap),
        .Done       (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- reference model ----------------
    bit         m_running;
    bit         m_done_phase;
    bit         m_prev;
    int         m_pos;
    int         m_len;
    int         m_passes;
    int         m_burst;
    logic [7:0] m_start;
    logic [7:0] e_addr;
    logic       e_valid, e_busy, e_wrap, e_done;

    // Predicts outputs after the coming clock edge from the current inputs.
    task automatic model_eval();
        bit stp;
`ifdef BPMC_STEP_EDGE_DET_EN
        stp = M_IN && !m_prev;
`else
        stp = M_IN;
`endif
        if (!Reset) begin
            m_prev = 0; m_running = 0; m_done_phase = 0;
            m_pos = 0; m_len = 1; m_passes = 0; m_burst = 0; m_start = 8'h00;
            e_addr = 8'h00; e_valid = 0; e_busy = 0; e_wrap = 0; e_done = 0;
            return;
        end
        m_prev = M_IN;
        e_wrap = 0;
        e_done = 0;
        if (Stop) begin
            m_running = 0; m_done_phase = 0;
            e_valid = 0; e_busy = 0;
        end else if (m_done_phase) begin
            m_done_phase = 0;
            e_valid = 0; e_busy = 0;
        end else if (m_running) begin
            if (stp) begin
                m_pos++;
                if (m_pos == m_len) begin
                    m_pos = 0;
                    if (m_passes < 255) m_passes++;
                    e_wrap = 1;
                    if (m_burst != 0 && m_passes == m_burst) begin
                        m_running = 0; m_done_phase = 1;
                        e_valid = 0; e_done = 1;
                    end
                end
                e_addr = 8'((int'(m_start) + m_pos) % 256);
            end
        end else begin
            if (Start) begin
                m_start   = Start_Addr;
                m_len     = ((int'(End_Addr) - int'(Start_Addr) + 256) % 256) + 1;
                m_burst   = Burst_Cnt;
                m_pos     = 0;
                m_passes  = 0;
                m_running = 1;
                e_addr = Start_Addr; e_valid = 1; e_busy = 1;
            end else begin
                e_valid = 0; e_busy = 0;
            end
        end
    endtask

    task automatic drive(input logic m, input logic st, input logic sp);
        M_IN = m; Start = st; Stop = sp;
        model_eval();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] s, input logic [7:0] e, input logic [7:0] b);
        Start_Addr = s; End_Addr = e; Burst_Cnt = b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if ({Addr, Addr_Valid, Busy, Wrap, Done} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset: got addr=%h v=%b b=%b w=%b d=%b, want all zero",
                     Addr, Addr_Valid, Busy, Wrap, Done);
        end
    endtask

    task automatic test_burst();
        int wraps = 0, dones = 0;
        set_cfg(8'h10, 8'h13, 8'd2);
        drive(1'b0, 1'b1, 1'b0);
        set_cfg(8'hA0, 8'hA5, 8'd7);   // post-start changes must not matter
        for (int i = 0; i < 26; i++) begin
            drive((i % 3 == 0) && (i < 24), 1'b0, 1'b0);
            wraps += Wrap; dones += Done;
            vectors++;
            if ({Addr, Addr_Valid, Busy, Wrap, Done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
                miscompares++;
                $display("FAIL burst cyc%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         Addr, Addr_Valid, Busy, Wrap, Done, e_addr, e_valid, e_busy, e_wrap, e_done);
            end
        end
        vectors++;
        if (wraps != 2 || dones != 1 || Addr !== 8'h10 || Addr_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_summary: got wraps=%0d dones=%0d addr=%h v=%b want 2 1 10 0",
                     wraps, dones, Addr, Addr_Valid);
        end
    endtask

    task automatic test_wrap_continuous();
        int wraps = 0;
        set_cfg(8'hFE, 8'h01, 8'd0);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) begin
            drive(i % 3 == 0, 1'b0, 1'b0);
            wraps += Wrap;
            vectors++;
            if ({Addr, Addr_Valid, Busy, Wrap, Done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
                miscompares++;
                $display("FAIL wrap_cont cyc%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         Addr, Addr_Valid, Busy, Wrap, Done, e_addr, e_valid, e_busy, e_wrap, e_done);
            end
        end
        vectors++;
        if (wraps != 1 || Addr !== 8'h00 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_cont_summary: got wraps=%0d addr=%h busy=%b want 1 00 1", wraps, Addr, Busy);
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stop();
        set_cfg(8'h10, 8'h1F, 8'd0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);   // stop collides with a step at 0x12
        vectors++;
        if ({Addr, Addr_Valid, Busy, Wrap, Done} !== {8'h12, 4'b0000} ||
            {Addr, Addr_Valid, Busy, Wrap, Done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
            miscompares++;
            $display("FAIL stop: got %h %b%b%b%b want 12 0000", Addr, Addr_Valid, Busy, Wrap, Done);
        end
        drive(1'b1, 1'b0, 1'b0);   // step in IDLE ignored
        set_cfg(8'h40, 8'h44, 8'd1);
        drive(1'b0, 1'b1, 1'b0);
        vectors++;
        if ({Addr, Addr_Valid, Busy} !== {8'h40, 2'b11} || {Addr, Addr_Valid, Busy} !== {e_addr, e_valid, e_busy}) begin
            miscompares++;
            $display("FAIL restart: got %h %b%b want 40 11", Addr, Addr_Valid, Busy);
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_start_conflict();
        set_cfg(8'h30, 8'h33, 8'd1);
        drive(1'b0, 1'b1, 1'b1);
        vectors++;
        if (Addr_Valid !== 1'b0 || Busy !== 1'b0 || Busy !== e_busy) begin
            miscompares++;
            $display("FAIL start_stop_idle: got v=%b b=%b want 0 0", Addr_Valid, Busy);
        end
        drive(1'b0, 1'b1, 1'b0);
        set_cfg(8'h99, 8'h9A, 8'd3);
        for (int i = 0; i < 12; i++) begin
            drive(i % 2 == 0, 1'b1, 1'b0);   // Start held during RUN/DONE
            vectors++;
            if ({Addr, Addr_Valid, Busy, Wrap, Done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
                miscompares++;
                $display("FAIL start_in_run cyc%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         Addr, Addr_Valid, Busy, Wrap, Done, e_addr, e_valid, e_busy, e_wrap, e_done);
            end
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_start_eq_end();
        int wraps = 0;
        set_cfg(8'h55, 8'h55, 8'd3);
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(i % 2 == 0, 1'b0, 1'b0);
            wraps += Wrap;
            vectors++;
            if ({Addr, Addr_Valid, Busy, Wrap, Done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
                miscompares++;
                $display("FAIL start_eq_end cyc%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         Addr, Addr_Valid, Busy, Wrap, Done, e_addr, e_valid, e_busy, e_wrap, e_done);
            end
        end
        vectors++;
        if (wraps != 3) begin
            miscompares++;
            $display("FAIL start_eq_end_wraps: got %0d want 3", wraps);
        end
    endtask

    task automatic test_held_high();
        int want;
`ifdef BPMC_STEP_EDGE_DET_EN
        want = 8'h21;
`else
        want = 8'h25;
`endif
        set_cfg(8'h20, 8'h3F, 8'd0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (int'(Addr) != want || Addr !== e_addr) begin
            miscompares++;
            $display("FAIL held_high: got addr=%h want %h", Addr, 8'(want));
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        set_cfg(8'h70, 8'h71, 8'd1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);   // enters DONE
        set_cfg(8'h80, 8'h82, 8'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0);   // ignored in DONE, taken in IDLE
            vectors++;
            if ({Addr, Addr_Valid, Busy, Wrap, Done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         Addr, Addr_Valid, Busy, Wrap, Done, e_addr, e_valid, e_busy, e_wrap, e_done);
            end
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            logic [7:0] s;
            s = 8'($urandom);
            set_cfg(s, 8'(s + 8'($urandom_range(0, 5))), 8'($urandom_range(0, 3)));
            Reset = ($urandom_range(0, 99) != 0);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
            vectors++;
            if ({Addr, Addr_Valid, Busy, Wrap, Done} !== {e_addr, e_valid, e_busy, e_wrap, e_done}) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         Addr, Addr_Valid, Busy, Wrap, Done, e_addr, e_valid, e_busy, e_wrap, e_done);
            end
        end
        Reset = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset = 1'b0; M_IN = 1'b0; Start = 1'b0; Stop = 1'b0;
        set_cfg(8'h00, 8'h00, 8'h00);
        test_reset();
        test_burst();
        test_wrap_continuous();
        test_stop();
        test_start_conflict();
        test_start_eq_end();
        test_held_high();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
